// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch PC sequencer with one-entry decode buffer and redirect kill.
// Optional FETCH_PERF_CNT_EN adds stall_cnt_o, a saturating count of memory-wait and decode-stall cycles.
module fetch_sequencer #(
    parameter int                      ARCHITECTURE = 32,
    parameter logic [ARCHITECTURE-1:0] RESET_VECTOR = 32'h00000000,
    parameter logic [ARCHITECTURE-1:0] PC_INC       = 32'h00000004
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic                    stall_i,
    input  logic                    redirect_valid_i,
    input  logic [ARCHITECTURE-1:0] redirect_pc_i,
    output logic                    imem_req_o,
    output logic [ARCHITECTURE-1:0] imem_addr_o,
    input  logic                    imem_ack_i,
    input  logic [31:0]             imem_rdata_i,
    output logic                    instr_valid_o,
    output logic [31:0]             instr_o,
    output logic [ARCHITECTURE-1:0] instr_pc_o,
    output logic [ARCHITECTURE-1:0] pc_o,
    output logic                    busy_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cnt_o
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [ARCHITECTURE-1:0] pc_q, pc_d;
    logic [31:0]             instr_q, instr_d;
    logic [ARCHITECTURE-1:0] instr_pc_q, instr_pc_d;
    logic                    instr_valid_q, instr_valid_d;
    logic                    kill_q, kill_d;
    logic [ARCHITECTURE-1:0] pending_pc_q, pending_pc_d;

    logic [1:0] resume_state;
    assign resume_state = run_i ? FETCH : IDLE;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        kill_d        = kill_q;
        pending_pc_d  = pending_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end
                if (run_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // The request is never withdrawn; a redirect without ack is parked until the ack drains it.
                if (imem_ack_i) begin
                    if (redirect_valid_i) begin
                        pc_d    = redirect_pc_i;
                        kill_d  = 1'b0;
                        state_d = resume_state;
                    end else if (kill_q) begin
                        pc_d    = pending_pc_q;
                        kill_d  = 1'b0;
                        state_d = resume_state;
                    end else begin
                        instr_d       = imem_rdata_i;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + PC_INC;
                        state_d       = DELIVER;
                    end
                end else if (redirect_valid_i) begin
                    kill_d       = 1'b1;
                    pending_pc_d = redirect_pc_i;
                end
            end
            DELIVER: begin
                if (redirect_valid_i) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_pc_i;
                    state_d       = resume_state;
                end else if (!stall_i) begin
                    instr_valid_d = 1'b0;
                    state_d       = resume_state;
                end
            end
            default: begin
                state_d       = IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            kill_q        <= 1'b0;
            pending_pc_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            kill_q        <= kill_d;
            pending_pc_q  <= pending_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == FETCH && !imem_ack_i) || (state_q == DELIVER && stall_i))
            && stall_cnt_q != 32'hFFFFFFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign imem_req_o    = (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed table-driven bench for fetch_sequencer, plus reset and PC-wrap sequences.
module tb_fetch_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .run_i            (run),
        .stall_i          (stall),
        .redirect_valid_i (rv),
        .redirect_pc_i    (rpc),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_ack_i       (ack),
        .imem_rdata_i     (rdata),
        .instr_valid_o    (valid),
        .instr_o          (instr),
        .instr_pc_o       (ipc),
        .pc_o             (pc),
        .busy_o           (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt)
`endif
    );

    typedef struct {
        logic        run, stall, rv;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr, ipc;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic i_run, input logic i_stall, input logic i_rv, input logic [31:0] i_rpc,
                       input logic i_ack, input logic [31:0] i_rdata,
                       input logic e_req, input logic [31:0] e_pc, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_busy);
        vec_t v;
        v.run = i_run; v.stall = i_stall; v.rv = i_rv; v.rpc = i_rpc; v.ack = i_ack; v.rdata = i_rdata;
        v.req = e_req; v.pc = e_pc; v.valid = e_valid; v.instr = e_instr; v.ipc = e_ipc; v.busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_run, input logic i_stall, input logic i_rv, input logic [31:0] i_rpc,
                         input logic i_ack, input logic [31:0] i_rdata);
        run = i_run; stall = i_stall; rv = i_rv; rpc = i_rpc; ack = i_ack; rdata = i_rdata;
    endtask

    initial begin
        //   run stall rv  rpc            ack rdata         req pc            val instr         ipc           busy
        add(H, L, L, 32'h0,        L, 32'h0,        H, 32'h0,        L, 32'h0,        32'h0,        H);
        add(H, L, L, 32'h0,        H, 32'h11,       L, 32'h4,        H, 32'h11,       32'h0,        H);
        add(H, L, L, 32'h0,        L, 32'h0,        H, 32'h4,        L, 32'h11,       32'h0,        H);
        add(H, L, L, 32'h0,        H, 32'h22,       L, 32'h8,        H, 32'h22,       32'h4,        H);
        add(H, H, L, 32'h0,        L, 32'h0,        L, 32'h8,        H, 32'h22,       32'h4,        H);
        add(H, H, L, 32'h0,        L, 32'h0,        L, 32'h8,        H, 32'h22,       32'h4,        H);
        add(H, H, L, 32'h0,        L, 32'h0,        L, 32'h8,        H, 32'h22,       32'h4,        H);
        add(H, L, L, 32'h0,        L, 32'h0,        H, 32'h8,        L, 32'h22,       32'h4,        H);
        add(H, L, L, 32'h0,        H, 32'h33,       L, 32'hC,        H, 32'h33,       32'h8,        H);
        add(H, L, L, 32'h0,        L, 32'h0,        H, 32'hC,        L, 32'h33,       32'h8,        H);
        // redirect while outstanding: address frozen, late 0xDEAD must never be delivered
        add(H, L, H, 32'h100,      L, 32'h0,        H, 32'hC,        L, 32'h33,       32'h8,        H);
        add(H, L, L, 32'h0,        L, 32'h0,        H, 32'hC,        L, 32'h33,       32'h8,        H);
        add(H, L, L, 32'h0,        H, 32'hDEAD,     H, 32'h100,      L, 32'h33,       32'h8,        H);
        add(H, L, H, 32'h200,      H, 32'h44,       H, 32'h200,      L, 32'h33,       32'h8,        H);
        add(H, L, L, 32'h0,        H, 32'h55,       L, 32'h204,      H, 32'h55,       32'h200,      H);
        add(H, H, L, 32'h0,        L, 32'h0,        L, 32'h204,      H, 32'h55,       32'h200,      H);
        add(H, H, H, 32'h300,      L, 32'h0,        H, 32'h300,      L, 32'h55,       32'h200,      H);
        // run dropped mid-fetch: request completes, delivers, then idles
        add(L, L, L, 32'h0,        L, 32'h0,        H, 32'h300,      L, 32'h55,       32'h200,      H);
        add(L, L, L, 32'h0,        H, 32'h66,       L, 32'h304,      H, 32'h66,       32'h300,      H);
        add(L, L, L, 32'h0,        L, 32'h0,        L, 32'h304,      L, 32'h66,       32'h300,      L);

        rst = 1'b1;
        #12;
        check("reset_req", {31'b0, req}, 32'h0);
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_instr", instr, 32'h0);
        check("reset_ipc", ipc, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            tick();
            check($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i), addr, vecs[i].pc);
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d_instr", i), instr, vecs[i].instr);
            check($sformatf("v%0d_ipc", i), ipc, vecs[i].ipc);
            check($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].busy});
        end

        // async reset between edges during an outstanding fetch
        drive(H, L, L, 32'h0, L, 32'h0);
        tick();
        check("pre_rst_req", {31'b0, req}, 32'h1);
        check("pre_rst_addr", addr, 32'h304);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'b0, req}, 32'h0);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'h0);
        drive(L, L, L, 32'h0, H, 32'hBAD);
        tick();
        #2;
        rst = 1'b0;
        tick();
        check("late_ack_valid", {31'b0, valid}, 32'h0);
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_pc", pc, 32'h0);
        check("late_ack_req", {31'b0, req}, 32'h0);

        // redirect to the top of the address space, then wrap
        drive(H, L, H, 32'hFFFFFFFC, L, 32'h0);
        tick();
        check("wrap_addr", addr, 32'hFFFFFFFC);
        check("wrap_req", {31'b0, req}, 32'h1);
        drive(H, L, L, 32'h0, L, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wrap_wait%0d_addr", i), addr, 32'hFFFFFFFC);
        end
        drive(H, L, L, 32'h0, H, 32'h77);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_instr", instr, 32'h77);
        check("wrap_ipc", ipc, 32'hFFFFFFFC);
        check("wrap_valid", {31'b0, valid}, 32'h1);
        drive(H, H, L, 32'h0, L, 32'h0);
        tick();
        tick();
        check("wrap_stall_valid", {31'b0, valid}, 32'h1);
        check("wrap_stall_req", {31'b0, req}, 32'h0);
        drive(L, L, L, 32'h0, L, 32'h0);
        tick();
        check("wrap_idle_busy", {31'b0, busy}, 32'h0);
        check("wrap_idle_pc", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
